// File: rtl/pool_window_gen_if.sv
// pool_window_gen_if: pixel stream in, 2x2 window words plus strobes out
interface pool_window_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] out1;
  logic [DATA_WIDTH-1:0] out2;
  logic [DATA_WIDTH-1:0] out3;
  logic [DATA_WIDTH-1:0] out4;
  logic                  valid_out;
  logic                  frame_done;
  modport master (
    output valid_in, data_in,
    input  out1, out2, out3, out4, valid_out, frame_done
  );
  modport slave (
    input  valid_in, data_in,
    output out1, out2, out3, out4, valid_out, frame_done
  );
endinterface

// File: rtl/pool_window_gen.sv
// pool_window_gen: turns a raster pixel stream into non-overlapping 2x2 windows
module pool_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224
) (
  input logic              clk,
  input logic              reset,
  pool_window_gen_if.slave s
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  typedef enum logic [1:0] {TOP_ROW, BOTTOM_ROW, TAIL_ROW} state_t;
  state_t                state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] bl;
  logic [DATA_WIDTH-1:0] line_buf [IMG_WIDTH];
  logic                  last_col;
  logic                  last_row;
  logic                  next_tail;
  assign last_col  = col == CW'(IMG_WIDTH - 1);
  assign last_row  = row == RW'(IMG_HEIGHT - 1);
  assign next_tail = (IMG_HEIGHT % 2 == 1) && row == RW'(IMG_HEIGHT - 2);
  // top rows are parked in the line buffer until their bottom row arrives
  always_ff @(posedge clk)
    if (s.valid_in && state == TOP_ROW) line_buf[col] <= s.data_in;
  // raster position, row-role FSM and registered window/strobe outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= TOP_ROW;
      col          <= '0;
      row          <= '0;
      bl           <= '0;
      s.out1       <= '0;
      s.out2       <= '0;
      s.out3       <= '0;
      s.out4       <= '0;
      s.valid_out  <= 1'b0;
      s.frame_done <= 1'b0;
    end else begin
      s.valid_out  <= 1'b0;
      s.frame_done <= 1'b0;
      if (s.valid_in) begin
        col          <= last_col ? '0 : col + 1'b1;
        s.frame_done <= last_col && last_row;
        if (last_col) begin
          row   <= last_row ? '0 : row + 1'b1;
          state <= last_row ? TOP_ROW :
                   state == TOP_ROW ? BOTTOM_ROW :
                   (state == BOTTOM_ROW && next_tail) ? TAIL_ROW : TOP_ROW;
        end
        if (state == BOTTOM_ROW && !col[0]) bl <= s.data_in;
        if (state == BOTTOM_ROW && col[0]) begin
          s.out1      <= line_buf[col - 1'b1];
          s.out2      <= line_buf[col];
          s.out3      <= bl;
          s.out4      <= s.data_in;
          s.valid_out <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: scoreboard bench for 4x4 and 5x5 window generators
module tb_pool_window_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pool_window_gen_if #(.DATA_WIDTH(32)) if0 ();
  pool_window_gen_if #(.DATA_WIDTH(32)) if1 ();
  pool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut0 (.clk(clk), .reset(reset), .s(if0));
  pool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut1 (.clk(clk), .reset(reset), .s(if1));
  typedef struct {int d; int due; logic [127:0] w;} exp_t;
  exp_t        wq[$];
  exp_t        dq[$];
  int          pass_cnt = 0;
  int          total = 0;
  logic [31:0] fr [2][25];
  int          pos [2] = '{0, 0};
  int          wd  [2] = '{4, 5};
  int          ht  [2] = '{4, 5};
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic int first_idx(input bit win, input int d);
    if (win) begin
      foreach (wq[i]) if (wq[i].d == d) return i;
    end else begin
      foreach (dq[i]) if (dq[i].d == d) return i;
    end
    return -1;
  endfunction
  task automatic mon(input int d, input logic vo, input logic fd, input logic [127:0] o);
    int i;
    for (i = first_idx(1, d); i >= 0 && wq[i].due < cyc; i = first_idx(1, d)) begin
      check($sformatf("missed_window%0d", d), 0, 1);
      wq.delete(i);
    end
    for (i = first_idx(0, d); i >= 0 && dq[i].due < cyc; i = first_idx(0, d)) begin
      check($sformatf("missed_done%0d", d), 0, 1);
      dq.delete(i);
    end
    if (vo) begin
      i = first_idx(1, d);
      if (i < 0) check($sformatf("spurious_valid%0d", d), 1, 0);
      else begin
        check($sformatf("window%0d", d), o, wq[i].w);
        check($sformatf("win_latency%0d", d), cyc, wq[i].due);
        wq.delete(i);
      end
    end
    if (fd) begin
      i = first_idx(0, d);
      if (i < 0) check($sformatf("spurious_done%0d", d), 1, 0);
      else begin
        check($sformatf("done_latency%0d", d), cyc, dq[i].due);
        dq.delete(i);
      end
    end
  endtask
  always @(negedge clk)
    if (!reset) begin
      mon(0, if0.valid_out, if0.frame_done, {if0.out1, if0.out2, if0.out3, if0.out4});
      mon(1, if1.valid_out, if1.frame_done, {if1.out1, if1.out2, if1.out3, if1.out4});
    end
  // reference: remember the whole frame; every odd-row/odd-col pixel closes a window
  task automatic send(input int d, input logic [31:0] v, input int gap);
    int p, r, c, w;
    w = wd[d];
    p = pos[d];
    fr[d][p] = v;
    r = p / w;
    c = p % w;
    if (r % 2 == 1 && c % 2 == 1)
      wq.push_back('{d, cyc + 1, {fr[d][p-w-1], fr[d][p-w], fr[d][p-1], v}});
    if (p == w * ht[d] - 1) dq.push_back('{d, cyc + 1, 128'd0});
    pos[d] = (p + 1) % (w * ht[d]);
    if (d == 0) begin if0.valid_in = 1'b1; if0.data_in = v; end
    else begin if1.valid_in = 1'b1; if1.data_in = v; end
    @(posedge clk); #1;
    if0.valid_in = 1'b0;
    if1.valid_in = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask
  task automatic frame(input int d, input int base, input int gap);
    for (int i = 0; i < wd[d] * ht[d]; i++) send(d, 32'(base + i), gap);
  endtask
  task automatic drain(input string name);
    for (int k = 0; k < 10 && (wq.size() != 0 || dq.size() != 0); k++) begin @(posedge clk); #1; end
    check(name, 128'(wq.size() + dq.size()), 0);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_out0"}, {if0.out1, if0.out2, if0.out3, if0.out4}, 0);
    check({tag, "_flags0"}, {if0.valid_out, if0.frame_done}, 0);
    check({tag, "_out1"}, {if1.out1, if1.out2, if1.out3, if1.out4}, 0);
    check({tag, "_flags1"}, {if1.valid_out, if1.frame_done}, 0);
  endtask
  initial begin
    if0.valid_in = 1'b0; if0.data_in = '0;
    if1.valid_in = 1'b0; if1.data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    frame(0, 0, 0);
    drain("t1_drain");
    frame(0, 0, 3);
    drain("t2_drain");
    frame(1, 0, 0);
    drain("t3_drain");
    send(0, 32'hFFFF_FFFF, 0);
    send(0, 32'h8000_0000, 0);
    for (int i = 0; i < 14; i++) send(0, $urandom | 32'h8000_0000, 0);
    drain("t4_drain");
    for (int i = 0; i < 7; i++) send(0, 32'(i), 0);
    check("t5_pre_reset_q", 128'(wq.size()), 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_reset");
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    pos = '{0, 0};
    wq.delete();
    dq.delete();
    @(posedge clk); #1;
    frame(0, 0, 0);
    drain("t5_drain");
    frame(0, 0, 0);
    frame(0, 100, 0);
    drain("t6_drain");
    for (int f = 0; f < 3; f++)
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < wd[d] * ht[d]; i++) send(d, $urandom, $urandom_range(0, 2));
    drain("rand_drain");
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
